// File: rtl/x_cmd_parse.sv
// UART byte-stream command parser: CMD/ADDR_H/ADDR_L[/WDATA] frames become SRAM requests; read data returns on tx.
// Optional macro X_CMD_PARSE_WACK_EN: completed writes answer with an ACK byte (8'h06) on the tx port.
module x_cmd_parse #(
  parameter logic [15:0] p_timeout = 16'd60000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_data,
  output logic         o_tx_valid,
  output logic [7:0]   o_tx_data,
  input  logic         i_tx_accept,
  output logic [15:0]  o_valid,
  input  logic [15:0]  i_accept,
  output logic         o_rd_n_wr,
  output logic [15:0]  o_addr,
  output logic [7:0]   o_wdata,
  input  logic [15:0]  i_ready,
  input  logic [127:0] i_rdata,
  output logic         o_drop
);

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_AH     = 3'd1,
    S_AL     = 3'd2,
    S_WD     = 3'd3,
    S_ISSUE  = 3'd4,
    S_RDWAIT = 3'd5,
    S_TX     = 3'd6
  } state_t;

  // Broadcast only applies to writes; reads always target a single lane.
  function automatic logic [15:0] target_mask(input logic rd, input logic bc, input logic [3:0] idx);
    logic [15:0] m;
    if (!rd && bc) begin
      m = 16'hFFFF;
    end else begin
      m = 16'h0001 << idx;
    end
    return m;
  endfunction

  state_t       state_r, state_s;
  logic         cmd_rd_r, cmd_rd_s;
  logic         cmd_bc_r, cmd_bc_s;
  logic [3:0]   cmd_idx_r, cmd_idx_s;
  logic [7:0]   ah_r, ah_s;
  logic [7:0]   al_r, al_s;
  logic [15:0]  cnt_r, cnt_s;
  logic [3:0]   idx_r, idx_s;
  logic [15:0]  target_r, target_s;
  logic [15:0]  acc_r, acc_s;
  logic [15:0]  valid_r, valid_s;
  logic         rd_n_wr_r, rd_n_wr_s;
  logic [15:0]  addr_r, addr_s;
  logic [7:0]   wdata_r, wdata_s;
  logic         tx_valid_r, tx_valid_s;
  logic [7:0]   tx_data_r, tx_data_s;
  logic [7:0]   lane_data_s;
  logic         lane_ready_s;
  logic         timeout_s;

  assign lane_data_s  = i_rdata[{idx_r, 3'b000} +: 8];
  assign lane_ready_s = i_ready[idx_r];
  assign timeout_s    = (cnt_r == (p_timeout - 16'd1));

  // Drop is combinational so it flags the offending byte in its own cycle.
  assign o_drop = i_rx_valid & ((state_r == S_ISSUE) | (state_r == S_RDWAIT) | (state_r == S_TX));

  assign o_valid    = valid_r;
  assign o_rd_n_wr  = rd_n_wr_r;
  assign o_addr     = addr_r;
  assign o_wdata    = wdata_r;
  assign o_tx_valid = tx_valid_r;
  assign o_tx_data  = tx_data_r;

  // Next-state and next-register computation for the whole parser.
  always_comb begin
    state_s    = state_r;
    cmd_rd_s   = cmd_rd_r;
    cmd_bc_s   = cmd_bc_r;
    cmd_idx_s  = cmd_idx_r;
    ah_s       = ah_r;
    al_s       = al_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    target_s   = target_r;
    acc_s      = acc_r;
    valid_s    = valid_r;
    rd_n_wr_s  = rd_n_wr_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    tx_valid_s = tx_valid_r;
    tx_data_s  = tx_data_r;
    case (state_r)
      S_CMD: begin
        if (i_rx_valid) begin
          cmd_rd_s  = i_rx_data[7];
          cmd_bc_s  = i_rx_data[4];
          cmd_idx_s = i_rx_data[3:0];
          cnt_s     = 16'd0;
          state_s   = S_AH;
        end else begin
          state_s = S_CMD;
        end
      end
      S_AH: begin
        if (i_rx_valid) begin
          ah_s    = i_rx_data;
          cnt_s   = 16'd0;
          state_s = S_AL;
        end else if (timeout_s) begin
          cnt_s   = 16'd0;
          state_s = S_CMD;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_AL: begin
        if (i_rx_valid) begin
          al_s  = i_rx_data;
          cnt_s = 16'd0;
          if (cmd_rd_r) begin
            idx_s     = cmd_idx_r;
            target_s  = target_mask(1'b1, cmd_bc_r, cmd_idx_r);
            valid_s   = target_s;
            acc_s     = 16'd0;
            rd_n_wr_s = 1'b1;
            addr_s    = {ah_r, i_rx_data};
            state_s   = S_ISSUE;
          end else begin
            state_s = S_WD;
          end
        end else if (timeout_s) begin
          cnt_s   = 16'd0;
          state_s = S_CMD;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_WD: begin
        if (i_rx_valid) begin
          cnt_s     = 16'd0;
          idx_s     = cmd_idx_r;
          target_s  = target_mask(1'b0, cmd_bc_r, cmd_idx_r);
          valid_s   = target_s;
          acc_s     = 16'd0;
          rd_n_wr_s = 1'b0;
          addr_s    = {ah_r, al_r};
          wdata_s   = i_rx_data;
          state_s   = S_ISSUE;
        end else if (timeout_s) begin
          cnt_s   = 16'd0;
          state_s = S_CMD;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_ISSUE: begin
        acc_s = acc_r | (i_accept & target_r);
        if (acc_s == target_r) begin
          valid_s = 16'd0;
          acc_s   = 16'd0;
          if (rd_n_wr_r) begin
            // A ready on the final accept cycle must not be lost.
            if (lane_ready_s) begin
              tx_data_s  = lane_data_s;
              tx_valid_s = 1'b1;
              state_s    = S_TX;
            end else begin
              state_s = S_RDWAIT;
            end
          end else begin
`ifdef X_CMD_PARSE_WACK_EN
            tx_data_s  = 8'h06;
            tx_valid_s = 1'b1;
            state_s    = S_TX;
`else
            state_s = S_CMD;
`endif
          end
        end else begin
          valid_s = target_r & ~acc_s;
        end
      end
      S_RDWAIT: begin
        if (lane_ready_s) begin
          tx_data_s  = lane_data_s;
          tx_valid_s = 1'b1;
          state_s    = S_TX;
        end else begin
          state_s = S_RDWAIT;
        end
      end
      S_TX: begin
        if (i_tx_accept) begin
          tx_valid_s = 1'b0;
          state_s    = S_CMD;
        end else begin
          tx_valid_s = 1'b1;
        end
      end
      default: begin
        state_s    = S_CMD;
        valid_s    = 16'd0;
        acc_s      = 16'd0;
        cnt_s      = 16'd0;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= S_CMD;
      cmd_rd_r   <= 1'b0;
      cmd_bc_r   <= 1'b0;
      cmd_idx_r  <= 4'd0;
      ah_r       <= 8'd0;
      al_r       <= 8'd0;
      cnt_r      <= 16'd0;
      idx_r      <= 4'd0;
      target_r   <= 16'd0;
      acc_r      <= 16'd0;
      valid_r    <= 16'd0;
      rd_n_wr_r  <= 1'b0;
      addr_r     <= 16'd0;
      wdata_r    <= 8'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      cmd_rd_r   <= cmd_rd_s;
      cmd_bc_r   <= cmd_bc_s;
      cmd_idx_r  <= cmd_idx_s;
      ah_r       <= ah_s;
      al_r       <= al_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      target_r   <= target_s;
      acc_r      <= acc_s;
      valid_r    <= valid_s;
      rd_n_wr_r  <= rd_n_wr_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      tx_valid_r <= tx_valid_s;
      tx_data_r  <= tx_data_s;
    end
  end

endmodule

// File: tb/tb_x_cmd_parse.sv
// Directed scoreboard bench for x_cmd_parse; honours X_CMD_PARSE_WACK_EN when defined.
`timescale 1ns/1ps
module tb_x_cmd_parse;

  localparam logic [15:0] P = 16'd20;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_accept;
  logic [15:0]  valid;
  logic [15:0]  accept;
  logic         rd_n_wr;
  logic [15:0]  addr;
  logic [7:0]   wdata;
  logic [15:0]  ready;
  logic [127:0] rdata;
  logic         drop;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] mask;
  } req_t;

  req_t       req_q[$];
  logic [7:0] tx_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  x_cmd_parse #(.p_timeout(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_accept(tx_accept),
    .o_valid(valid), .i_accept(accept), .o_rd_n_wr(rd_n_wr), .o_addr(addr),
    .o_wdata(wdata), .i_ready(ready), .i_rdata(rdata), .o_drop(drop)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_req(input logic rd, input logic [15:0] a, input logic [7:0] wd, input logic [15:0] m);
    req_t e;
    e.rd = rd; e.addr = a; e.wdata = wd; e.mask = m;
    req_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    chk("no_drop_on_capture", drop, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_req();
    req_t e;
    int k = 0;
    while (valid == 16'd0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", valid != 16'd0, 1'b1);
    if (req_q.size() != 0) begin
      e = req_q.pop_front();
      chk("req_mask", valid, e.mask);
      chk("req_rd_n_wr", rd_n_wr, e.rd);
      chk("req_addr", addr, e.addr);
      chk("req_wdata", wdata, e.wdata);
    end else begin
      chk("req_unexpected", req_q.size(), 1'b1);
    end
  endtask

  task automatic acc(input logic [15:0] m, input logic [15:0] exp_valid);
    accept = m;
    @(negedge clk);
    accept = 16'd0;
    chk("valid_after_accept", valid, exp_valid);
  endtask

  task automatic wait_tx(input int hold);
    logic [7:0] e;
    int k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("tx_seen", tx_valid, 1'b1);
    e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hXX;
    chk("tx_data", tx_data, e);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("tx_hold_valid", tx_valid, 1'b1);
      chk("tx_hold_data", tx_data, e);
    end
    tx_accept = 1'b1;
    @(negedge clk);
    tx_accept = 1'b0;
    chk("tx_released", tx_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_accept = 1'b0;
    accept = 16'd0; ready = 16'd0; rdata = 128'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 16'd0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'd0);
    chk("rst_rd_n_wr", rd_n_wr, 1'b0);
    chk("rst_addr", addr, 16'd0);
    chk("rst_wdata", wdata, 8'd0);
    chk("rst_drop", drop, 1'b0);
    rst = 1'b1;

    // Single write to lane 3
    exp_req(1'b0, 16'h0123, 8'h5A, 16'h0008);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h23); send_byte(8'h5A);
    wait_req();
    @(negedge clk);
    chk("issue_stable_valid", valid, 16'h0008);
    chk("issue_stable_addr", addr, 16'h0123);
    acc(16'h0001, 16'h0008);
    acc(16'h0008, 16'h0000);
`ifdef X_CMD_PARSE_WACK_EN
    tx_q.push_back(8'h06);
    wait_tx(1);
`else
    @(negedge clk);
    chk("no_write_ack", tx_valid, 1'b0);
`endif
    chk("addr_held_idle", addr, 16'h0123);

    // Broadcast write, staggered accepts
    exp_req(1'b0, 16'h0010, 8'hFF, 16'hFFFF);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h10); send_byte(8'hFF);
    wait_req();
    acc(16'h000F, 16'hFFF0);
    @(negedge clk);
    chk("bcast_hold", valid, 16'hFFF0);
    acc(16'h0FF0, 16'hF000);
    acc(16'hF000, 16'h0000);
`ifdef X_CMD_PARSE_WACK_EN
    tx_q.push_back(8'h06);
    wait_tx(1);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bcast_single_request", valid, 16'd0);
    end

    // Read lane 12 with stray ready on lane 2
    exp_req(1'b1, 16'h1FFF, 8'hFF, 16'h1000);
    tx_q.push_back(8'hC3);
    send_byte(8'h8C); send_byte(8'h1F); send_byte(8'hFF);
    wait_req();
    ready = 16'h0004; rdata[23:16] = 8'h55;
    @(negedge clk);
    ready = 16'd0;
    chk("read_stray_ready_valid", valid, 16'h1000);
    chk("read_stray_ready_tx", tx_valid, 1'b0);
    acc(16'h1000, 16'h0000);
    ready = 16'h0004;
    @(negedge clk);
    ready = 16'd0;
    chk("rdwait_ignores_lane2", tx_valid, 1'b0);
    @(negedge clk);
    ready = 16'h1000; rdata[103:96] = 8'hC3;
    chk("read_before_ready", tx_valid, 1'b0);
    @(negedge clk);
    ready = 16'd0;
    chk("read_latency", tx_valid, 1'b1);
    wait_tx(5);

    // Byte during S_RDWAIT is dropped
    exp_req(1'b1, 16'h0040, 8'hFF, 16'h0020);
    tx_q.push_back(8'h9A);
    send_byte(8'h85); send_byte(8'h00); send_byte(8'h40);
    wait_req();
    acc(16'h0020, 16'h0000);
    rx_valid = 1'b1; rx_data = 8'h77;
    #1;
    chk("drop_pulse", drop, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    chk("drop_one_cycle", drop, 1'b0);
    ready = 16'h0020; rdata[47:40] = 8'h9A;
    @(negedge clk);
    ready = 16'd0;
    wait_tx(1);

    // Partial frame times out
    send_byte(8'h8C); send_byte(8'h00);
    for (int i = 0; i <= int'(P); i++) begin
      @(negedge clk);
      chk("timeout_no_request", valid, 16'd0);
    end
    // Next frame: read with bit4 set, last byte lands on the timeout cycle
    exp_req(1'b1, 16'h1234, 8'hFF, 16'h0002);
    tx_q.push_back(8'h5E);
    send_byte(8'h91); send_byte(8'h12);
    repeat (int'(P) - 2) @(negedge clk);
    send_byte(8'h34);
    wait_req();
    accept = 16'h0002; ready = 16'h0002; rdata[15:8] = 8'h5E;
    @(negedge clk);
    accept = 16'd0; ready = 16'd0;
    chk("coincident_valid_off", valid, 16'd0);
    chk("coincident_ready_tx", tx_valid, 1'b1);
    wait_tx(1);

    // Reset during S_ISSUE
    exp_req(1'b0, 16'h0002, 8'h33, 16'h0080);
    send_byte(8'h07); send_byte(8'h00); send_byte(8'h02); send_byte(8'h33);
    wait_req();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", valid, 16'd0);
    chk("async_rst_addr", addr, 16'd0);
    chk("async_rst_wdata", wdata, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_req(1'b0, 16'h0004, 8'h44, 16'h0004);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h04); send_byte(8'h44);
    wait_req();
    acc(16'h0004, 16'h0000);
`ifdef X_CMD_PARSE_WACK_EN
    tx_q.push_back(8'h06);
    wait_tx(1);
`endif

    chk("req_queue_drained", req_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/x_cmd_parse.md
X_CMD_PARSE -- requirements
Module: x_cmd_parse

Interface
REQ-001 SHALL have parameter p_timeout, default 16'd60000, meaning the number of idle clocks between received bytes before a partial frame is discarded.
REQ-002 SHALL have ports: i_clk  in  1  system clock.
REQ-003 SHALL have ports: i_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: i_rx_valid  in  1  one-cycle pulse, UART byte received.
REQ-005 SHALL have ports: i_rx_data  in  8  received byte.
REQ-006 SHALL have ports: o_tx_valid  out  1  byte to UART transmitter valid.
REQ-007 SHALL have ports: o_tx_data  out  8  byte to UART transmitter.
REQ-008 SHALL have ports: i_tx_accept  in  1  transmitter took the byte.
REQ-009 SHALL have ports: o_valid  out  16  per-SRAM request valid.
REQ-010 SHALL have ports: i_accept  in  16  per-SRAM one-cycle request accept.
REQ-011 SHALL have ports: o_rd_n_wr  out  1, o_addr  out  16, o_wdata  out  8; request fields, broadcast to all SRAMs.
REQ-012 SHALL have ports: i_ready  in  16  per-SRAM one-cycle read-data ready.
REQ-013 SHALL have ports: i_rdata  in  128  read data, SRAM n on bits [8n+7:8n].
REQ-014 SHALL have ports: o_drop  out  1  one-cycle pulse, received byte discarded.

Function
REQ-015 Frame: CMD, ADDR_H, ADDR_L, then WDATA for writes only. CMD bit7 = rd_n_wr, bit4 = broadcast (writes only; ignored on reads), bits3:0 = SRAM index; bits6:5 ignored.
REQ-016 States: S_CMD, S_AH, S_AL, S_WD, S_ISSUE, S_RDWAIT, S_TX; reset state S_CMD.
REQ-017 Byte transitions: S_CMD->S_AH, S_AH->S_AL; S_AL->S_ISSUE on reads, S_AL->S_WD on writes; S_WD->S_ISSUE.
REQ-018 A byte is captured only on a cycle where i_rx_valid=1 in S_CMD/S_AH/S_AL/S_WD.
REQ-019 A byte arriving in any other state SHALL be discarded and o_drop SHALL pulse high in that same cycle.
REQ-020 Timeout: a 16-bit counter clears on every captured byte and counts in S_AH/S_AL/S_WD. When it reaches p_timeout-1, the state SHALL return to S_CMD next cycle with no request issued; if a byte arrives in that same cycle, the byte wins.
REQ-021 S_ISSUE target mask: one-hot of index, or 16'hFFFF for broadcast writes. o_valid = target mask AND NOT accepted mask. The accepted mask accumulates i_accept bits for targeted lanes; i_accept on non-targeted lanes is ignored.
REQ-022 o_rd_n_wr, o_addr and o_wdata SHALL be registered, SHALL be stable throughout S_ISSUE, and SHALL hold their last value otherwise.
REQ-023 When the accepted mask covers the target mask, o_valid SHALL be 0 in the next cycle; writes then go to S_CMD (or S_TX, see Configuration) and reads go to S_RDWAIT. An accept arriving in the first S_ISSUE cycle counts.
REQ-024 S_RDWAIT: on i_ready[index]=1, capture i_rdata[8*index+:8] into o_tx_data and go to S_TX. i_ready on other lanes is ignored. An i_ready[index] that coincides with the final accept cycle SHALL also be captured.
REQ-025 S_TX: o_tx_valid=1 with o_tx_data held until i_tx_accept=1, then S_CMD next cycle.
REQ-026 Read latency: from the final i_accept to o_tx_valid is the SRAM ready delay plus 1 clock.

Reset
REQ-027 While i_rst=0: state S_CMD, o_valid=0, o_tx_valid=0, o_tx_data=0, o_rd_n_wr=0, o_addr=0, o_wdata=0, o_drop=0, masks and counter 0.
REQ-028 Reset mid-frame or mid-request SHALL abandon the frame or request immediately; no partial state survives.

Configuration
REQ-029 Macro X_CMD_PARSE_WACK_EN: when defined, a completed write SHALL go to S_TX with o_tx_data=8'h06 (ACK), handshaked as in REQ-025. When undefined, a completed write returns directly to S_CMD and the tx port is used only for read data.

Verification
REQ-030 Write 80? no: bytes 0x03,0x01,0x23,0x5A -> o_valid=16'h0008, o_rd_n_wr=0, o_addr=16'h0123, o_wdata=8'h5A; after i_accept[3], o_valid=0; ACK 0x06 only when X_CMD_PARSE_WACK_EN is defined.
REQ-031 Broadcast write 0x10,0x00,0x10,0xFF, i_accept lanes arriving staggered in 3 groups -> o_valid drops per lane and reaches 0 only after the last lane; exactly one request.
REQ-032 Read 0x8C,0x1F,0xFF, then i_accept[12], then i_ready[12] with lane 12 data = 0xC3 and i_ready[2]=1 earlier -> o_tx_data=0xC3, o_tx_valid held 5 cycles until i_tx_accept.
REQ-033 Bytes 0x8C,0x00 then idle p_timeout clocks -> no o_valid; the next frame parses normally.
REQ-034 A byte sent during S_RDWAIT -> o_drop pulses; the read completes unaffected.
REQ-035 i_rst=0 asserted during S_ISSUE -> o_valid=0 asynchronously; after release, a new write completes correctly.
